mixed_fft_8_stream_ctrl: RTL and testbench
==========================================

// Module: mixed_fft_8_stream_ctrl
// PURPOSE
//  Host-side initiator for the external load/unload ports of the 8-point mixed-precision FFT core.
//  Accepts a valid/ready sample stream, writes it bit-reversed into the core input bank, pulses start,
//  waits for done, then reads the result bank sequentially and emits it as a valid/ready stream with last.
//  Sits between the stream fabric and the FFT core; it is the only driver of the core ext_* ports.
// PARAMETERS
//  MAX_N          8     FFT length; number of beats per frame in and out
//  ADDR_WIDTH     3     log2(MAX_N)
//  RD_LAT         1     core read latency, cycles from ext_rd_addr to valid rd_data
//  IN_BANK        0     ext_bank_sel value while loading
//  OUT_BANK       1     ext_bank_sel value while unloading (bank holding the final stage)
//  TIMEOUT_CYCLES 1024  done watchdog limit (used only with FFT_TIMEOUT_EN)
// PORTS
//  clk          in  1            clock
//  rst          in  1            reset, asynchronous, active-low
//  s_valid      in  1            input sample valid
//  s_ready      out 1            input sample ready
//  s_data       in  24           input sample, 24-bit memory format
//  m_valid      out 1            result valid
//  m_ready      in  1            result ready
//  m_data       out 24           result sample
//  m_last       out 1            high on beat MAX_N-1 of a result frame
//  fft_start    out 1            one-cycle start pulse to the core
//  fft_n        out ADDR_WIDTH+1 constant MAX_N
//  fft_done     in  1            core done (one-cycle pulse)
//  fft_error    in  1            core error
//  ext_wr_en    out 1            core write enable
//  ext_wr_addr  out ADDR_WIDTH   core write address
//  ext_wr_data  out 24           core write data
//  ext_bank_sel out 1            core bank select
//  ext_rd_addr  out ADDR_WIDTH   core read address
//  ext_reading  out 1            high during UNLOAD; core read port owned by this block
//  rd_data      in  24           core read data
//  busy         out 1            high in any state except IDLE
//  err          out 1            sticky frame error flag
// BEHAVIOUR
//  - Reset: all outputs 0 except fft_n=MAX_N, ext_bank_sel=IN_BANK; state IDLE; counters 0.
//  - States: IDLE, LOAD, START, WAIT_DONE, RD_ISSUE, RD_WAIT, OUT_HOLD.
//  - s_ready=1 only in IDLE and LOAD. A beat is accepted when s_valid&s_ready.
//  - IDLE: accepted beat -> LOAD, clears err, counts as beat 0.
//  - LOAD: beat i registered: next cycle ext_wr_en=1, ext_wr_addr=bitrev(i), ext_wr_data=s_data.
//    After beat MAX_N-1 is accepted -> START (s_ready drops same cycle beat MAX_N-1 completes).
//  - START: fft_start=1 for exactly one cycle (cycle after the last write) -> WAIT_DONE.
//  - WAIT_DONE: fft_done=1 -> RD_ISSUE, read counter j=0. fft_error=1 in START/WAIT_DONE -> err=1, IDLE.
//    Done and error in the same cycle: error wins.
//  - RD_ISSUE: ext_reading=1, ext_bank_sel=OUT_BANK, ext_rd_addr=j -> RD_WAIT.
//  - RD_WAIT: wait RD_LAT cycles, capture rd_data into m_data -> OUT_HOLD.
//  - OUT_HOLD: m_valid=1, m_data and m_last (j==MAX_N-1) stable until m_ready. On handshake:
//    j<MAX_N-1 -> j+1, RD_ISSUE; j==MAX_N-1 -> IDLE. Latency RD_LAT+1 cycles per beat minimum.
//  - ext_reading and ext_bank_sel=OUT_BANK held through RD_ISSUE/RD_WAIT/OUT_HOLD; ext_wr_en never high then.
//  - Counters wrap only via frame completion; no partial frames; s_valid ignored outside IDLE/LOAD.
//  - Async reset mid-frame: immediate return to reset values; core is not told (next start reloads all).
// CONFIGURATION
//  FFT_TIMEOUT_EN defined: WAIT_DONE cycle counter; reaching TIMEOUT_CYCLES without fft_done
//    -> err=1, IDLE. Counter clears on entry to WAIT_DONE.
//  FFT_TIMEOUT_EN undefined: no counter; WAIT_DONE waits for fft_done or fft_error indefinitely.
// TESTING
//  - Load 0x000001..0x000008 with s_valid held -> ext_wr_addr 0,4,2,6,1,5,3,7, data in order, one fft_start.
//  - Core model returns rd_data=0x0A0000+addr, m_ready=1 -> m_data 0x0A0000..0x0A0007, m_last on 8th only.
//  - m_ready toggled 1/0 each cycle -> m_data/m_last stable while m_valid&!m_ready; 8 beats, no loss.
//  - fft_error pulsed in WAIT_DONE -> err=1, state IDLE, no m_valid; next frame accepted clears err.
//  - FFT_TIMEOUT_EN, TIMEOUT_CYCLES=16, no fft_done -> err=1 at cycle 16 of WAIT_DONE, busy=0.
//  - rst low after 5 load beats -> all outputs reset next edge-free; fresh 8-beat frame completes normally.

Source files
------------

// File: rtl/mixed_fft_8_stream_ctrl_if.sv
// ----------------------------------------------------------------------------
// mixed_fft_8_stream_ctrl_if
//   Bundles every signal of the stream controller except clk and rst.
//   These signals are the input sample stream, the result stream, and the
//   start/done/external-memory port of the 8-point FFT core.
//
//   modport master : the stream controller. It drives s_ready, the m_*
//                    outputs, fft_start, fft_n, the ext_* outputs, busy and
//                    err.
//   modport slave  : the environment, i.e. the stream fabric plus the FFT
//                    core. It drives s_valid, s_data, m_ready, fft_done,
//                    fft_error and rd_data.
//
//   Parameters: ADDR_WIDTH (core address width), DATA_W (sample width).
// ----------------------------------------------------------------------------
interface mixed_fft_8_stream_ctrl_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_W     = 24
);
    // input sample stream
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_W-1:0]     s_data;
    // result stream
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_W-1:0]     m_data;
    logic                  m_last;
    // core control
    logic                  fft_start;
    logic [ADDR_WIDTH:0]   fft_n;
    logic                  fft_done;
    logic                  fft_error;
    // core external memory port
    logic                  ext_wr_en;
    logic [ADDR_WIDTH-1:0] ext_wr_addr;
    logic [DATA_W-1:0]     ext_wr_data;
    logic                  ext_bank_sel;
    logic [ADDR_WIDTH-1:0] ext_rd_addr;
    logic                  ext_reading;
    logic [DATA_W-1:0]     rd_data;
    // status
    logic                  busy;
    logic                  err;

    modport master (
        input  s_valid, s_data, m_ready, fft_done, fft_error, rd_data,
        output s_ready, m_valid, m_data, m_last, fft_start, fft_n,
               ext_wr_en, ext_wr_addr, ext_wr_data, ext_bank_sel,
               ext_rd_addr, ext_reading, busy, err
    );

    modport slave (
        output s_valid, s_data, m_ready, fft_done, fft_error, rd_data,
        input  s_ready, m_valid, m_data, m_last, fft_start, fft_n,
               ext_wr_en, ext_wr_addr, ext_wr_data, ext_bank_sel,
               ext_rd_addr, ext_reading, busy, err
    );
endinterface

// File: rtl/mixed_fft_8_stream_ctrl.sv
// ----------------------------------------------------------------------------
// mixed_fft_8_stream_ctrl
//   Host-side initiator for the load/unload ports of the 8-point FFT core.
//   A frame of MAX_N samples is taken from a valid/ready stream and written
//   into the core input bank in bit-reversed address order. The block then
//   pulses fft_start and waits for fft_done. After that it reads the result
//   bank sequentially and emits the results as a valid/ready stream, with
//   m_last marking the final beat of the frame.
//
//   Ports
//     clk  : clock
//     rst  : asynchronous, active-low reset
//     bus  : mixed_fft_8_stream_ctrl_if.master. It carries the s_* input
//            stream, the m_* output stream, fft_start/fft_n/fft_done/
//            fft_error, ext_wr_*/ext_bank_sel/ext_rd_addr/ext_reading/
//            rd_data, and the busy and err status flags.
//
//   Build option
//     FFT_TIMEOUT_EN : when defined, a watchdog counts cycles spent in
//                      WAIT_DONE. Reaching TIMEOUT_CYCLES without fft_done
//                      flags err and returns the block to IDLE. When not
//                      defined, WAIT_DONE waits for fft_done or fft_error
//                      with no time limit.
// ----------------------------------------------------------------------------
module mixed_fft_8_stream_ctrl #(
    parameter int   MAX_N          = 8,
    parameter int   ADDR_WIDTH     = 3,
    parameter int   RD_LAT         = 1,
    parameter int   DATA_W         = 24,
    parameter logic IN_BANK        = 1'b0,
    parameter logic OUT_BANK       = 1'b1,
    parameter int   TIMEOUT_CYCLES = 1024
) (
    input logic                       clk,
    input logic                       rst,
    mixed_fft_8_stream_ctrl_if.master bus
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MAX_N - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_DONE,
        RD_ISSUE,
        RD_WAIT,
        OUT_HOLD
    } state_t;

    state_t state, next_state;

    logic [ADDR_WIDTH-1:0] in_cnt;
    logic [ADDR_WIDTH-1:0] rd_cnt;
    logic [LAT_W-1:0]      lat_cnt;

    logic                  vld_p1;
    logic [ADDR_WIDTH-1:0] wr_addr_p1;
    logic [DATA_W-1:0]     wr_data_p1;
    logic [DATA_W-1:0]     rd_data_p1;

    logic accept;
    logic last_in;
    logic last_out;
    logic lat_hit;
    logic out_hs;
    logic frame_err;
    logic to_hit;
    logic reading_next;

    function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] r;
        for (int b = 0; b < ADDR_WIDTH; b++) begin
            r[b] = a[ADDR_WIDTH-1-b];
        end
        return r;
    endfunction

    assign accept   = bus.s_valid && bus.s_ready;
    assign last_in  = (in_cnt == LAST_IDX);
    assign last_out = (rd_cnt == LAST_IDX);
    assign lat_hit  = (lat_cnt == LAT_W'(RD_LAT - 1));
    assign out_hs   = bus.m_valid && bus.m_ready;

`ifdef FFT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    // Held at zero outside WAIT_DONE, so every wait starts counting from 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (state != WAIT_DONE) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign to_hit = (state == WAIT_DONE) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Priority in WAIT_DONE: error beats done (same cycle), and done beats
    // a watchdog expiry that lands in the same cycle.
    always_comb begin
        next_state = state;
        frame_err  = 1'b0;
        unique case (state)
            IDLE:      if (accept) next_state = LOAD;
            LOAD:      if (accept && last_in) next_state = START;
            START: begin
                if (bus.fft_error) begin
                    frame_err  = 1'b1;
                    next_state = IDLE;
                end else begin
                    next_state = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.fft_error) begin
                    frame_err  = 1'b1;
                    next_state = IDLE;
                end else if (bus.fft_done) begin
                    next_state = RD_ISSUE;
                end else if (to_hit) begin
                    frame_err  = 1'b1;
                    next_state = IDLE;
                end
            end
            RD_ISSUE:  next_state = RD_WAIT;
            RD_WAIT:   if (lat_hit) next_state = OUT_HOLD;
            OUT_HOLD:  if (out_hs) next_state = last_out ? IDLE : RD_ISSUE;
            default:   next_state = IDLE;
        endcase
    end

    assign reading_next = (next_state == RD_ISSUE) || (next_state == RD_WAIT) ||
                          (next_state == OUT_HOLD);

    // Load stage: an accepted beat appears on the core write port one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1     <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
            in_cnt     <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                wr_addr_p1 <= bitrev(in_cnt);
                wr_data_p1 <= bus.s_data;
                in_cnt     <= last_in ? '0 : in_cnt + 1'b1;
            end
        end
    end

    // Unload stage: the read address is the beat counter itself. Data is
    // captured after RD_LAT wait cycles and held until the handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt     <= '0;
            lat_cnt    <= '0;
            rd_data_p1 <= '0;
        end else begin
            if (state == WAIT_DONE && next_state == RD_ISSUE) begin
                rd_cnt <= '0;
            end else if (state == OUT_HOLD && out_hs) begin
                rd_cnt <= last_out ? '0 : rd_cnt + 1'b1;
            end
            if (state == RD_WAIT && !lat_hit) begin
                lat_cnt <= lat_cnt + 1'b1;
            end else begin
                lat_cnt <= '0;
            end
            if (state == RD_WAIT && lat_hit) begin
                rd_data_p1 <= bus.rd_data;
            end
        end
    end

    // Control outputs are registered from next_state, so each one changes
    // on the same edge as the state it belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.s_ready      <= 1'b0;
            bus.busy         <= 1'b0;
            bus.err          <= 1'b0;
            bus.fft_start    <= 1'b0;
            bus.m_valid      <= 1'b0;
            bus.m_last       <= 1'b0;
            bus.ext_reading  <= 1'b0;
            bus.ext_bank_sel <= IN_BANK;
        end else begin
            bus.s_ready      <= (next_state == IDLE) || (next_state == LOAD);
            bus.busy         <= (next_state != IDLE);
            bus.fft_start    <= (state == START) && (next_state == WAIT_DONE);
            bus.m_valid      <= (next_state == OUT_HOLD);
            bus.m_last       <= (next_state == OUT_HOLD) && last_out;
            bus.ext_reading  <= reading_next;
            bus.ext_bank_sel <= reading_next ? OUT_BANK : IN_BANK;
            if (state == IDLE && accept) begin
                bus.err <= 1'b0;
            end else if (frame_err) begin
                bus.err <= 1'b1;
            end
        end
    end

    assign bus.ext_wr_en   = vld_p1;
    assign bus.ext_wr_addr = wr_addr_p1;
    assign bus.ext_wr_data = wr_data_p1;
    assign bus.ext_rd_addr = rd_cnt;
    assign bus.m_data      = rd_data_p1;
    assign bus.fft_n       = (ADDR_WIDTH + 1)'(MAX_N);

endmodule

// File: tb/tb_mixed_fft_8_stream_ctrl.sv
module tb_mixed_fft_8_stream_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    mixed_fft_8_stream_ctrl_if #(.ADDR_WIDTH(3), .DATA_W(24)) bus ();

    mixed_fft_8_stream_ctrl #(
        .MAX_N(8), .ADDR_WIDTH(3), .RD_LAT(1), .DATA_W(24),
        .IN_BANK(1'b0), .OUT_BANK(1'b1), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [2:0]  wr_addr_log  [128];
    logic [23:0] wr_data_log  [128];
    logic [23:0] out_data_log [128];
    logic        out_last_log [128];
    int wr_n       = 0;
    int out_n      = 0;
    int start_n    = 0;
    int start_wr_n = 0;

    logic [2:0] brev_tab [8];

    // Core model: one-cycle registered read of result word 0x0A0000 + addr.
    always @(posedge clk) begin
        bus.rd_data <= 24'h0A0000 | 24'(bus.ext_rd_addr);
    end

    // Log writes, start pulses and output handshakes between active edges.
    always @(negedge clk) begin
        if (bus.ext_wr_en === 1'b1) begin
            wr_addr_log[wr_n % 128] <= bus.ext_wr_addr;
            wr_data_log[wr_n % 128] <= bus.ext_wr_data;
            wr_n <= wr_n + 1;
        end
        if (bus.fft_start === 1'b1) begin
            start_n    <= start_n + 1;
            start_wr_n <= wr_n;
        end
        if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
            out_data_log[out_n % 128] <= bus.m_data;
            out_last_log[out_n % 128] <= bus.m_last;
            out_n <= out_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [23:0] base);
        int i = 0;
        int guard = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = base;
        while (i < 8 && guard < 100) begin
            @(negedge clk);
            if (bus.s_ready === 1'b1) begin
                @(posedge clk);
                #1;
                i++;
                bus.s_data = base + 24'(i);
            end else begin
                @(posedge clk);
                #1;
            end
            guard++;
        end
        bus.s_valid = 1'b0;
        check("load_beats_accepted", i, 8);
    endtask

    task automatic pulse_done();
        bus.fft_done = 1'b1;
        cycles(1);
        bus.fft_done = 1'b0;
    endtask

    task automatic drain(input int base, input bit toggle);
        int   guard = 0;
        logic hold  = 1'b0;
        logic [23:0] hd = '0;
        logic hl = 1'b0;
        bus.m_ready = 1'b1;
        while (out_n < base + 8 && guard < 300) begin
            @(negedge clk);
            if (hold) begin
                check("hold_m_valid", bus.m_valid, 1'b1);
                check("hold_m_data", bus.m_data, hd);
                check("hold_m_last", bus.m_last, hl);
            end
            if (bus.m_valid === 1'b1) begin
                check("out_reading", bus.ext_reading, 1'b1);
                check("out_bank_sel", bus.ext_bank_sel, 1'b1);
                check("out_no_write", bus.ext_wr_en, 1'b0);
            end
            hold = (bus.m_valid === 1'b1) && (bus.m_ready === 1'b0);
            hd   = bus.m_data;
            hl   = bus.m_last;
            @(posedge clk);
            #1;
            guard++;
            if (toggle) bus.m_ready = ~bus.m_ready;
        end
        bus.m_ready = 1'b0;
        cycles(3);
        check("out_beat_count", out_n - base, 8);
        check("post_frame_busy", bus.busy, 1'b0);
        check("post_frame_reading", bus.ext_reading, 1'b0);
        check("post_frame_bank", bus.ext_bank_sel, 1'b0);
    endtask

    task automatic run_frame(input logic [23:0] data_base, input bit toggle);
        int wr_base  = wr_n;
        int out_base = out_n;
        int st_base  = start_n;
        send_frame(data_base);
        @(negedge clk);
        check("s_ready_after_load", bus.s_ready, 1'b0);
        check("busy_after_load", bus.busy, 1'b1);
        check("err_after_load", bus.err, 1'b0);
        cycles(3);
        check("start_pulses", start_n - st_base, 1);
        check("start_after_writes", start_wr_n - wr_base, 8);
        check("no_m_valid_before_done", bus.m_valid, 1'b0);
        for (int k = 0; k < 8; k++) begin
            check("wr_addr", wr_addr_log[(wr_base + k) % 128], brev_tab[k]);
            check("wr_data", wr_data_log[(wr_base + k) % 128], data_base + 24'(k));
        end
        pulse_done();
        drain(out_base, toggle);
        for (int k = 0; k < 8; k++) begin
            check("m_data", out_data_log[(out_base + k) % 128], 24'h0A0000 + 24'(k));
            check("m_last", out_last_log[(out_base + k) % 128], (k == 7) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        int out_snap;
        int wr_snap;
        brev_tab[0] = 3'd0; brev_tab[1] = 3'd4; brev_tab[2] = 3'd2; brev_tab[3] = 3'd6;
        brev_tab[4] = 3'd1; brev_tab[5] = 3'd5; brev_tab[6] = 3'd3; brev_tab[7] = 3'd7;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.m_ready   = 1'b0;
        bus.fft_done  = 1'b0;
        bus.fft_error = 1'b0;

        // Reset values while rst is held low.
        cycles(3);
        check("rst_s_ready", bus.s_ready, 1'b0);
        check("rst_m_valid", bus.m_valid, 1'b0);
        check("rst_m_last", bus.m_last, 1'b0);
        check("rst_m_data", bus.m_data, 24'h0);
        check("rst_fft_start", bus.fft_start, 1'b0);
        check("rst_fft_n", bus.fft_n, 4'd8);
        check("rst_wr_en", bus.ext_wr_en, 1'b0);
        check("rst_bank_sel", bus.ext_bank_sel, 1'b0);
        check("rst_reading", bus.ext_reading, 1'b0);
        check("rst_rd_addr", bus.ext_rd_addr, 3'd0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_err", bus.err, 1'b0);
        rst = 1'b1;
        cycles(1);
        check("idle_s_ready", bus.s_ready, 1'b1);
        check("idle_busy", bus.busy, 1'b0);

        // Frame 1: samples 1..8, m_ready held high.
        run_frame(24'h000001, 1'b0);

        // Frame 2: m_ready alternating every cycle.
        run_frame(24'h000101, 1'b1);

        // Core error while waiting for done.
        out_snap = out_n;
        send_frame(24'h000201);
        cycles(3);
        bus.fft_error = 1'b1;
        cycles(1);
        bus.fft_error = 1'b0;
        @(negedge clk);
        check("error_err", bus.err, 1'b1);
        check("error_busy", bus.busy, 1'b0);
        check("error_s_ready", bus.s_ready, 1'b1);
        check("error_m_valid", bus.m_valid, 1'b0);
        cycles(10);
        check("error_no_output", out_n - out_snap, 0);
        check("error_err_sticky", bus.err, 1'b1);

        // The next frame clears err and completes normally.
        run_frame(24'h000301, 1'b0);
        check("err_cleared", bus.err, 1'b0);

        // Done and error together: error wins.
        out_snap = out_n;
        send_frame(24'h000401);
        cycles(3);
        bus.fft_error = 1'b1;
        bus.fft_done  = 1'b1;
        cycles(1);
        bus.fft_error = 1'b0;
        bus.fft_done  = 1'b0;
        cycles(10);
        check("done_err_err", bus.err, 1'b1);
        check("done_err_busy", bus.busy, 1'b0);
        check("done_err_no_output", out_n - out_snap, 0);

`ifdef FFT_TIMEOUT_EN
        // Watchdog: no done, err must rise after 16 cycles of WAIT_DONE.
        send_frame(24'h000601);
        check("to_err_cleared", bus.err, 1'b0);
        cycles(10);
        check("to_err_early", bus.err, 1'b0);
        check("to_busy_early", bus.busy, 1'b1);
        cycles(10);
        check("to_err", bus.err, 1'b1);
        check("to_busy", bus.busy, 1'b0);
`endif

        // Asynchronous reset after five load beats.
        bus.s_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.s_data = 24'h000700 + 24'(k);
            cycles(1);
        end
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_s_ready", bus.s_ready, 1'b0);
        check("mid_rst_wr_en", bus.ext_wr_en, 1'b0);
        check("mid_rst_err", bus.err, 1'b0);
        check("mid_rst_wr_addr", bus.ext_wr_addr, 3'd0);
        check("mid_rst_bank_sel", bus.ext_bank_sel, 1'b0);
        bus.s_valid = 1'b0;
        cycles(2);
        rst = 1'b1;
        cycles(2);
        wr_snap = wr_n;
        check("post_rst_s_ready", bus.s_ready, 1'b1);
        run_frame(24'h000501, 1'b0);
        check("post_rst_writes", wr_n - wr_snap, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
